clint_bus_arbiter: RTL

- Round-robin arbiter that shares the single native valid/ready slave port of the CLINT timer/software-interrupt block between N_REQ bus requesters (e.g. CPU data port, debug module).
- Sits between the requesters and the CLINT.
- Allows one outstanding transaction at a time.
- Registers the granted request onto the downstream port and routes the response back to the requester that owns the grant.

---
 rtl/clint_bus_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/clint_bus_arbiter.sv
// Round-robin arbiter sharing the single CLINT valid/ready slave port between N_REQ requesters.
// Optional watchdog completion (port timeout_err) is built when CLINT_ARB_TIMEOUT_EN is defined.
module clint_bus_arbiter #(
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*ADDR_W-1:0]       req_address,
  input  logic [N_REQ*DATA_W-1:0]       req_wdata,
  input  logic [N_REQ*(DATA_W/8)-1:0]   req_wstrb,
  output logic [DATA_W-1:0]             req_rdata,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          m_valid,
  output logic [ADDR_W-1:0]             m_address,
  output logic [DATA_W-1:0]             m_wdata,
  output logic [DATA_W/8-1:0]           m_wstrb,
  input  logic [DATA_W-1:0]             m_rdata,
  input  logic                          m_ready,
  output logic [$clog2(N_REQ)-1:0]      grant_id
`ifdef CLINT_ARB_TIMEOUT_EN
  ,
  output logic                          timeout_err
`endif
);

  localparam int unsigned GW = $clog2(N_REQ);
  localparam int unsigned CW = GW + 1;
  localparam int unsigned SW = DATA_W / 8;

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65536) begin : g_param_check
    $error("clint_bus_arbiter: parameter out of range");
  end

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [GW-1:0]   ptr;
  logic [GW-1:0]   winner;
  logic [CW-1:0]   cand;
  logic            found;
  logic            done;
  logic            wd_hit;

  logic [ADDR_W-1:0] addr_arr  [N_REQ];
  logic [DATA_W-1:0] wdata_arr [N_REQ];
  logic [SW-1:0]     wstrb_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_address[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
    assign wstrb_arr[g] = req_wstrb[g*SW +: SW];
  end

  // First valid requester at or above the pointer, wrapping modulo N_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr} + CW'(k);
      if (cand >= CW'(N_REQ)) begin
        cand = cand - CW'(N_REQ);
      end
      if (!found && req_valid[cand[GW-1:0]]) begin
        found  = 1'b1;
        winner = cand[GW-1:0];
      end
    end
  end

`ifdef CLINT_ARB_TIMEOUT_EN
  localparam logic [31:0]       TO_WORD  = 32'hDEAD_BEEF;
  localparam logic [DATA_W-1:0] TO_RDATA = DATA_W'(TO_WORD);
  localparam logic [15:0]       WD_LAST  = 16'(TIMEOUT_CYC - 1);

  logic [15:0] wd_cnt;

  // Held at zero while IDLE so every BUSY period starts counting from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
    end else if (state == IDLE) begin
      wd_cnt <= '0;
    end else if (!m_ready) begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end

  assign wd_hit      = (state == BUSY) && !m_ready && (wd_cnt == WD_LAST);
  assign timeout_err = wd_hit;
`else
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    req_rdata = '0;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (m_ready) begin
          req_ready[grant_id] = 1'b1;
          req_rdata           = m_rdata;
          state_nxt           = IDLE;
        end
`ifdef CLINT_ARB_TIMEOUT_EN
        else if (wd_hit) begin
          req_ready[grant_id] = 1'b1;
          req_rdata           = TO_RDATA;
          state_nxt           = IDLE;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign m_valid = (state == BUSY);
  assign done    = (state == BUSY) && (state_nxt == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_address <= '0;
      m_wdata   <= '0;
      m_wstrb   <= '0;
      grant_id  <= '0;
      ptr       <= '0;
    end else begin
      if (state == IDLE && found) begin
        m_address <= addr_arr[winner];
        m_wdata   <= wdata_arr[winner];
        m_wstrb   <= wstrb_arr[winner];
        grant_id  <= winner;
      end
      // The requester just served drops to lowest priority.
      if (done) begin
        ptr <= (grant_id == GW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
    end
  end

endmodule
